// File: rtl/uart_tx_gen.sv
// UART transmitter: START, DATA (LSB first), optional PARITY, STOP on a registered tx line.
// Latency: the frame starts on the acceptance edge, or one edge later through the optional FIFO.
// Backpressure: tx_ready is low while a frame is in flight (or while the FIFO is full).
//
// Ports:
//   clk       - single clock, rising edge
//   rst       - asynchronous reset, active low
//   tx_valid  - tx_data offered
//   tx_data   - word to send, LSB first
//   tx_ready  - word accepted on an edge where tx_valid && tx_ready
//   tx        - registered serial line, idle high
//   busy      - FSM not in IDLE
//   done      - one-cycle pulse on the edge that returns STOP to IDLE
//
// Build option: define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry FIFO in
// front of the FSM (tx_ready then means "FIFO not full").

module uart_tx_gen #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 10420,
    parameter int PARITY_MODE  = 1,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_W);

    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic             HAS_PAR   = (PARITY_MODE != 0);
    localparam logic             PAR_ODD   = (PARITY_MODE == 2);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // Reject illegal configurations at elaboration.
    if (DATA_W < 5 || DATA_W > 9 || CLKS_PER_BIT < 2 ||
        PARITY_MODE < 0 || PARITY_MODE > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2) ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("uart_tx_gen: illegal parameter set");
    end

    logic [2:0]        r_state;
    logic [TMR_W-1:0]  r_tmr;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_shift;
    logic              r_par;
    logic              r_stop_cnt;
    logic              r_tx;
    logic              r_done;

    logic              w_bit_end;
    logic              w_src_vld;
    logic [DATA_W-1:0] w_src_dat;
    logic              w_start;

`ifdef UART_TX_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W:0]    r_wp;
    logic [PTR_W:0]    r_rp;
    logic              w_full;
    logic              w_empty;
    logic              w_push;

    assign w_empty   = (r_wp == r_rp);
    assign w_full    = (r_wp[PTR_W] != r_rp[PTR_W]) &&
                       (r_wp[PTR_W-1:0] == r_rp[PTR_W-1:0]);
    assign tx_ready  = !w_full;
    assign w_push    = tx_valid && !w_full;
    assign w_src_vld = !w_empty;
    assign w_src_dat = r_mem[r_rp[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + (PTR_W+1)'(1);
            end
            if (w_start) begin
                r_rp <= r_rp + (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp[PTR_W-1:0]] <= tx_data;
        end
    end
`else
    assign tx_ready  = (r_state == S_IDLE) && rst;
    assign w_src_vld = tx_valid;
    assign w_src_dat = tx_data;
`endif

    assign w_start   = (r_state == S_IDLE) && w_src_vld;
    assign w_bit_end = (r_tmr == TMR_LAST);

    assign tx   = r_tx;
    assign busy = (r_state != S_IDLE);
    assign done = r_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_tmr      <= '0;
            r_idx      <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        // Parity is fixed at capture so later tx_data changes cannot leak in.
                        r_state <= S_START;
                        r_tmr   <= '0;
                        r_shift <= w_src_dat;
                        r_par   <= (^w_src_dat) ^ PAR_ODD;
                        r_tx    <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state <= S_DATA;
                        r_tmr   <= '0;
                        r_idx   <= '0;
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_tmr <= '0;
                        if (r_idx == IDX_LAST) begin
                            if (HAS_PAR) begin
                                r_state <= S_PARITY;
                                r_tx    <= r_par;
                            end else begin
                                r_state    <= S_STOP;
                                r_stop_cnt <= 1'b0;
                                r_tx       <= 1'b1;
                            end
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_state    <= S_STOP;
                        r_tmr      <= '0;
                        r_stop_cnt <= 1'b0;
                        r_tx       <= 1'b1;
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end
                S_STOP: begin
                    // The timer wraps between stop bits; r_stop_cnt tracks which one is ending.
                    if (w_bit_end) begin
                        r_tmr <= '0;
                        if (r_stop_cnt == STOP_LAST) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_stop_cnt <= r_stop_cnt + 1'b1;
                        end
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
